// File: rtl/router_ingress_arbiter.sv
// -----------------------------------------------------------------------------
// router_ingress_arbiter
//
// Round-robin arbiter that lets three packet sources share the single packet
// input port of the router. A source owns the port for one whole packet
// (header, payload, parity). The granted source is forwarded combinationally
// onto the router input. Every other source is stalled until the router is
// back in address decode.
//
// Ports
//   clock          rising-edge clock
//   resetn         synchronous active-low reset
//   src_pkt_valid  [2:0]  per-source packet valid (bit i = source i)
//   src_data_0..2  [DATA_W-1:0] per-source packet byte
//   src_busy       [2:0]  per-source stall; a source holds data/valid while 1
//   src_grant      [2:0]  registered one-hot grant
//   rtr_busy       router busy
//   rtr_pkt_valid  router packet valid
//   rtr_data_in    [DATA_W-1:0] router data
//   grant_id       [1:0]  index of the granted source (valid while src_grant != 0)
//   pkt_done       one-cycle pulse when a packet completes normally
//   timeout        one-cycle pulse when the DRAIN watchdog fires
// -----------------------------------------------------------------------------
module router_ingress_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 30
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [2:0]        src_pkt_valid,
  input  logic [DATA_W-1:0] src_data_0,
  input  logic [DATA_W-1:0] src_data_1,
  input  logic [DATA_W-1:0] src_data_2,
  output logic [2:0]        src_busy,
  output logic [2:0]        src_grant,
  input  logic              rtr_busy,
  output logic              rtr_pkt_valid,
  output logic [DATA_W-1:0] rtr_data_in,
  output logic [1:0]        grant_id,
  output logic              pkt_done,
  output logic              timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Last watchdog count before DRAIN gives up on the router.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t            state_r, state_s;
  logic [1:0]        gnt_r, gnt_s;
  logic [1:0]        rr_ptr_r, rr_ptr_s;
  logic              hdr_phase_r, hdr_phase_s;
  logic [7:0]        wd_cnt_r, wd_cnt_s;
  logic [2:0]        src_grant_r, src_grant_s;
  logic              pkt_done_r, pkt_done_s;
  logic              timeout_r, timeout_s;
  logic [1:0]        winner_s;
  logic              sel_valid_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [2:0]        sel_busy_s;

  // Successor in the mod-3 rotation; 2 wraps to 0, 3 never occurs.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    case (idx)
      2'd0:    rr_next = 2'd1;
      2'd1:    rr_next = 2'd2;
      default: rr_next = 2'd0;
    endcase
  endfunction

  // Highest-priority requester starting at the round-robin pointer.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] req);
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;
    p0 = ptr;
    p1 = rr_next(p0);
    p2 = rr_next(p1);
    if (req[p0]) begin
      rr_pick = p0;
    end else if (req[p1]) begin
      rr_pick = p1;
    end else begin
      rr_pick = p2;
    end
  endfunction

  assign winner_s = rr_pick(rr_ptr_r, src_pkt_valid);

  // Source-side mux: valid, data and stall pattern of the granted source.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_data_s  = '0;
    sel_busy_s  = 3'b111;
    case (gnt_r)
      2'd0: begin
        sel_valid_s = src_pkt_valid[0];
        sel_data_s  = src_data_0;
        sel_busy_s  = {2'b11, rtr_busy};
      end
      2'd1: begin
        sel_valid_s = src_pkt_valid[1];
        sel_data_s  = src_data_1;
        sel_busy_s  = {1'b1, rtr_busy, 1'b1};
      end
      2'd2: begin
        sel_valid_s = src_pkt_valid[2];
        sel_data_s  = src_data_2;
        sel_busy_s  = {rtr_busy, 2'b11};
      end
      default: begin
        sel_valid_s = 1'b0;
        sel_data_s  = '0;
        sel_busy_s  = 3'b111;
      end
    endcase
  end

  // Next-state and output logic of the arbitration FSM.
  always_comb begin
    state_s       = state_r;
    gnt_s         = gnt_r;
    rr_ptr_s      = rr_ptr_r;
    hdr_phase_s   = hdr_phase_r;
    wd_cnt_s      = wd_cnt_r;
    src_grant_s   = src_grant_r;
    pkt_done_s    = 1'b0;
    timeout_s     = 1'b0;
    src_busy      = 3'b111;
    rtr_pkt_valid = 1'b0;
    rtr_data_in   = '0;
    case (state_r)
      ST_IDLE: begin
        if ((src_pkt_valid != 3'b000) && !rtr_busy) begin
          gnt_s       = winner_s;
          rr_ptr_s    = rr_next(winner_s);
          hdr_phase_s = 1'b1;
          src_grant_s = 3'b001 << winner_s;
          state_s     = ST_PASS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PASS: begin
        rtr_pkt_valid = sel_valid_s;
        rtr_data_in   = sel_data_s;
        src_busy      = sel_busy_s;
        hdr_phase_s   = 1'b0;
        if (!sel_valid_s && hdr_phase_r) begin
          // Source withdrew before the header was taken: abort, keep rr_ptr.
          state_s     = ST_IDLE;
          gnt_s       = 2'd0;
          src_grant_s = 3'b000;
        end else if (!sel_valid_s && !rtr_busy) begin
          // Parity byte accepted this cycle.
          state_s  = ST_DRAIN;
          wd_cnt_s = 8'd0;
        end else begin
          state_s = ST_PASS;
        end
      end
      ST_DRAIN: begin
        wd_cnt_s = wd_cnt_r + 8'd1;
        if (!rtr_busy) begin
          state_s     = ST_IDLE;
          pkt_done_s  = 1'b1;
          gnt_s       = 2'd0;
          src_grant_s = 3'b000;
        end else if (wd_cnt_r == WD_LAST) begin
          state_s     = ST_IDLE;
          timeout_s   = 1'b1;
          gnt_s       = 2'd0;
          src_grant_s = 3'b000;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        gnt_s       = 2'd0;
        src_grant_s = 3'b000;
      end
    endcase
  end

  // State, grant and pulse registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      gnt_r       <= 2'd0;
      rr_ptr_r    <= 2'd0;
      hdr_phase_r <= 1'b0;
      wd_cnt_r    <= 8'd0;
      src_grant_r <= 3'b000;
      pkt_done_r  <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      rr_ptr_r    <= rr_ptr_s;
      hdr_phase_r <= hdr_phase_s;
      wd_cnt_r    <= wd_cnt_s;
      src_grant_r <= src_grant_s;
      pkt_done_r  <= pkt_done_s;
      timeout_r   <= timeout_s;
    end
  end

  assign src_grant = src_grant_r;
  assign grant_id  = gnt_r;
  assign pkt_done  = pkt_done_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_router_ingress_arbiter.sv
// -----------------------------------------------------------------------------
// tb_router_ingress_arbiter
//
// Directed bench for router_ingress_arbiter. A vector table covers reset,
// a single packet with a mid-payload stall, withdrawal, rotation after abort,
// busy at arbitration and reset mid-PASS. Hand-written loops cover the
// round-robin order and the DRAIN watchdog.
// Inputs change 1 ns after the rising edge; outputs are checked on the
// falling edge of the same cycle.
// -----------------------------------------------------------------------------
module tb_router_ingress_arbiter;

  logic       clock;
  logic       resetn;
  logic [2:0] src_pkt_valid;
  logic [7:0] src_data_0, src_data_1, src_data_2;
  logic [2:0] src_busy, src_grant;
  logic       rtr_busy;
  logic       rtr_pkt_valid;
  logic [7:0] rtr_data_in;
  logic [1:0] grant_id;
  logic       pkt_done, timeout;

  int n_checks;
  int n_fail;

  router_ingress_arbiter #(.DATA_W(8), .TIMEOUT(30)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .src_pkt_valid (src_pkt_valid),
    .src_data_0    (src_data_0),
    .src_data_1    (src_data_1),
    .src_data_2    (src_data_2),
    .src_busy      (src_busy),
    .src_grant     (src_grant),
    .rtr_busy      (rtr_busy),
    .rtr_pkt_valid (rtr_pkt_valid),
    .rtr_data_in   (rtr_data_in),
    .grant_id      (grant_id),
    .pkt_done      (pkt_done),
    .timeout       (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rstn;
    logic [2:0] v;
    logic [7:0] d0, d1, d2;
    logic       busy;
    logic [2:0] e_sb;
    logic [2:0] e_gn;
    logic [1:0] e_id;
    logic       e_rv;
    logic [7:0] e_rd;
    logic       e_dn;
    logic       e_to;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rstn, input logic [2:0] v, input logic [7:0] d0, d1, d2,
                     input logic busy, input logic [2:0] e_sb, e_gn, input logic [1:0] e_id,
                     input logic e_rv, input logic [7:0] e_rd, input logic e_dn, e_to);
    vec_t t;
    t.rstn = rstn; t.v = v; t.d0 = d0; t.d1 = d1; t.d2 = d2; t.busy = busy;
    t.e_sb = e_sb; t.e_gn = e_gn; t.e_id = e_id; t.e_rv = e_rv; t.e_rd = e_rd;
    t.e_dn = e_dn; t.e_to = e_to;
    vq.push_back(t);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // One clock cycle: apply inputs after the rising edge, return at falling edge.
  task automatic drive(input logic rstn, input logic [2:0] v, input logic [7:0] d0, d1, d2,
                       input logic busy);
    @(posedge clock);
    #1;
    resetn        = rstn;
    src_pkt_valid = v;
    src_data_0    = d0;
    src_data_1    = d1;
    src_data_2    = d2;
    rtr_busy      = busy;
    @(negedge clock);
  endtask

  function automatic logic [7:0] src_byte(input int g);
    case (g)
      0:       src_byte = 8'hA0;
      1:       src_byte = 8'hB0;
      default: src_byte = 8'hC0;
    endcase
  endfunction

  initial begin
    logic [18:0] act_b;
    logic [18:0] exp_b;
    logic [2:0]  one_g;
    logic [2:0]  rr_v;
    int          wd_c;
    bit          wd_seen;

    n_checks = 0;
    n_fail   = 0;
    resetn = 1'b0; src_pkt_valid = 3'b000; rtr_busy = 1'b0;
    src_data_0 = 8'hAA; src_data_1 = 8'hBB; src_data_2 = 8'hCC;
    repeat (2) @(posedge clock);

    //   rstn v       d0     d1     d2     bsy  src_busy gnt     id    rv    rd     dn    to
    add(1'b1, 3'b000, 8'hAA, 8'hBB, 8'hCC, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0); // 0 reset state
    add(1'b1, 3'b010, 8'hAA, 8'h0D, 8'hCC, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0); // 1 request src1
    add(1'b1, 3'b010, 8'hAA, 8'h0D, 8'hCC, 1'b0, 3'b101, 3'b010, 2'd1, 1'b1, 8'h0D, 1'b0, 1'b0); // 2 header
    add(1'b1, 3'b010, 8'hAA, 8'h11, 8'hCC, 1'b0, 3'b101, 3'b010, 2'd1, 1'b1, 8'h11, 1'b0, 1'b0); // 3
    add(1'b1, 3'b010, 8'hAA, 8'h22, 8'hCC, 1'b0, 3'b101, 3'b010, 2'd1, 1'b1, 8'h22, 1'b0, 1'b0); // 4
    add(1'b1, 3'b010, 8'hAA, 8'h33, 8'hCC, 1'b1, 3'b111, 3'b010, 2'd1, 1'b1, 8'h33, 1'b0, 1'b0); // 5 stall
    add(1'b1, 3'b010, 8'hAA, 8'h33, 8'hCC, 1'b1, 3'b111, 3'b010, 2'd1, 1'b1, 8'h33, 1'b0, 1'b0); // 6 stall
    add(1'b1, 3'b010, 8'hAA, 8'h33, 8'hCC, 1'b1, 3'b111, 3'b010, 2'd1, 1'b1, 8'h33, 1'b0, 1'b0); // 7 stall
    add(1'b1, 3'b010, 8'hAA, 8'h33, 8'hCC, 1'b0, 3'b101, 3'b010, 2'd1, 1'b1, 8'h33, 1'b0, 1'b0); // 8 release
    add(1'b1, 3'b000, 8'hAA, 8'h5A, 8'hCC, 1'b0, 3'b101, 3'b010, 2'd1, 1'b0, 8'h5A, 1'b0, 1'b0); // 9 parity
    add(1'b1, 3'b000, 8'hAA, 8'hBB, 8'hCC, 1'b1, 3'b111, 3'b010, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0); // 10 drain
    add(1'b1, 3'b000, 8'hAA, 8'hBB, 8'hCC, 1'b1, 3'b111, 3'b010, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0); // 11 drain
    add(1'b1, 3'b000, 8'hAA, 8'hBB, 8'hCC, 1'b0, 3'b111, 3'b010, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0); // 12 drain end
    add(1'b1, 3'b000, 8'hAA, 8'hBB, 8'hCC, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0); // 13 pkt_done
    add(1'b1, 3'b000, 8'hAA, 8'hBB, 8'hCC, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0); // 14
    add(1'b1, 3'b100, 8'hAA, 8'hBB, 8'hC1, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0); // 15 request src2
    add(1'b1, 3'b000, 8'hAA, 8'hBB, 8'hC1, 1'b0, 3'b011, 3'b100, 2'd2, 1'b0, 8'hC1, 1'b0, 1'b0); // 16 withdraw
    add(1'b1, 3'b000, 8'hAA, 8'hBB, 8'hCC, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0); // 17 idle, no done
    add(1'b1, 3'b110, 8'hAA, 8'hB1, 8'hC2, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0); // 18 rr=0 -> src1
    add(1'b1, 3'b110, 8'hAA, 8'hB1, 8'hC2, 1'b0, 3'b101, 3'b010, 2'd1, 1'b1, 8'hB1, 1'b0, 1'b0); // 19
    add(1'b1, 3'b100, 8'hAA, 8'hB2, 8'hC2, 1'b0, 3'b101, 3'b010, 2'd1, 1'b0, 8'hB2, 1'b0, 1'b0); // 20 parity
    add(1'b1, 3'b100, 8'hAA, 8'hBB, 8'hC2, 1'b0, 3'b111, 3'b010, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0); // 21 drain
    add(1'b1, 3'b100, 8'hAA, 8'hBB, 8'hC2, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0); // 22 idle, grant src2
    add(1'b1, 3'b100, 8'hAA, 8'hBB, 8'hC2, 1'b0, 3'b011, 3'b100, 2'd2, 1'b1, 8'hC2, 1'b0, 1'b0); // 23
    add(1'b1, 3'b000, 8'hAA, 8'hBB, 8'hC3, 1'b0, 3'b011, 3'b100, 2'd2, 1'b0, 8'hC3, 1'b0, 1'b0); // 24 parity
    add(1'b1, 3'b000, 8'hAA, 8'hBB, 8'hCC, 1'b0, 3'b111, 3'b100, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0); // 25 drain
    add(1'b1, 3'b001, 8'hA0, 8'hBB, 8'hCC, 1'b1, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0); // 26 busy arb
    add(1'b1, 3'b001, 8'hA0, 8'hBB, 8'hCC, 1'b1, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0); // 27
    add(1'b1, 3'b001, 8'hA0, 8'hBB, 8'hCC, 1'b1, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0); // 28
    add(1'b1, 3'b001, 8'hA0, 8'hBB, 8'hCC, 1'b1, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0); // 29
    add(1'b1, 3'b001, 8'hA0, 8'hBB, 8'hCC, 1'b1, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0); // 30
    add(1'b1, 3'b001, 8'hA0, 8'hBB, 8'hCC, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0); // 31 busy falls
    add(1'b1, 3'b001, 8'hA0, 8'hBB, 8'hCC, 1'b0, 3'b110, 3'b001, 2'd0, 1'b1, 8'hA0, 1'b0, 1'b0); // 32 grant src0
    add(1'b0, 3'b001, 8'hA1, 8'hBB, 8'hCC, 1'b0, 3'b110, 3'b001, 2'd0, 1'b1, 8'hA1, 1'b0, 1'b0); // 33 reset mid-PASS
    add(1'b1, 3'b000, 8'hAA, 8'hBB, 8'hCC, 1'b0, 3'b111, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0); // 34 reset values

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rstn, vq[i].v, vq[i].d0, vq[i].d1, vq[i].d2, vq[i].busy);
      act_b = {src_busy, src_grant, grant_id, rtr_pkt_valid, rtr_data_in, pkt_done, timeout};
      exp_b = {vq[i].e_sb, vq[i].e_gn, vq[i].e_id, vq[i].e_rv, vq[i].e_rd, vq[i].e_dn, vq[i].e_to};
      check($sformatf("vec%0d {busy,gnt,id,rv,rd,done,to}", i), 32'(act_b), 32'(exp_b));
    end

    // Round-robin from reset: all sources request continuously, 1-byte payloads.
    for (int k = 0; k < 6; k++) begin
      one_g = 3'b001 << (k % 3);
      rr_v  = 3'b111 & ~one_g;
      drive(1'b1, 3'b111, 8'hA0, 8'hB0, 8'hC0, 1'b0);
      check($sformatf("rr%0d idle grant", k), 32'(src_grant), 32'd0);
      check($sformatf("rr%0d idle done", k), 32'(pkt_done), (k > 0) ? 32'd1 : 32'd0);
      drive(1'b1, 3'b111, 8'hA0, 8'hB0, 8'hC0, 1'b0);
      check($sformatf("rr%0d grant", k), 32'(src_grant), 32'(one_g));
      check($sformatf("rr%0d grant_id", k), 32'(grant_id), 32'(k % 3));
      check($sformatf("rr%0d header", k), 32'(rtr_data_in), 32'(src_byte(k % 3)));
      drive(1'b1, 3'b111, 8'hA0, 8'hB0, 8'hC0, 1'b0);
      check($sformatf("rr%0d payload valid", k), 32'(rtr_pkt_valid), 32'd1);
      drive(1'b1, rr_v, 8'hA0, 8'hB0, 8'hC0, 1'b0);
      check($sformatf("rr%0d parity src_busy", k), 32'(src_busy), 32'(rr_v));
      drive(1'b1, 3'b111, 8'hA0, 8'hB0, 8'hC0, 1'b0);
      check($sformatf("rr%0d drain {busy,valid}", k), 32'({src_busy, rtr_pkt_valid}), 32'({3'b111, 1'b0}));
    end

    // Watchdog: router stays busy after parity.
    drive(1'b1, 3'b001, 8'hA0, 8'hB0, 8'hC0, 1'b0);
    drive(1'b1, 3'b001, 8'hA0, 8'hB0, 8'hC0, 1'b0);
    check("wd grant", 32'(src_grant), 32'(3'b001));
    drive(1'b1, 3'b000, 8'h77, 8'hB0, 8'hC0, 1'b0);
    check("wd parity data", 32'(rtr_data_in), 32'(8'h77));
    wd_seen = 1'b0;
    wd_c    = 0;
    for (int c = 0; c < 60; c++) begin
      drive(1'b1, 3'b000, 8'hA0, 8'hB0, 8'hC0, 1'b1);
      if (timeout === 1'b1) begin
        wd_seen = 1'b1;
        wd_c    = c;
        break;
      end
    end
    check("wd timeout seen", 32'(wd_seen), 32'd1);
    check("wd cycles after drain entry", 32'(wd_c), 32'd30);
    check("wd {grant,done}", 32'({src_grant, pkt_done}), 32'({3'b000, 1'b0}));
    drive(1'b1, 3'b000, 8'hA0, 8'hB0, 8'hC0, 1'b1);
    check("wd pulse one cycle", 32'(timeout), 32'd0);
    check("wd idle src_busy", 32'(src_busy), 32'(3'b111));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_ingress_arbiter.md
# router_ingress_arbiter

Round-robin arbiter that shares the router's single packet input port among three packet sources. It grants the port one whole packet at a time (header, payload, parity) and multiplexes the granted source onto the router input. It back-pressures every other source until the router returns to address decode. It sits between the source interfaces and the router top, driving the router's `pkt_valid` and `data_in` and consuming its `busy`.

## Interface
- `DATA_W`, default 8: packet byte width.
- `TIMEOUT`, default 30: DRAIN watchdog limit in cycles, range 1..255.

- `clock`  in  1  rising-edge clock.
- `resetn`  in  1  synchronous, active-low reset.
- `src_pkt_valid`  in  3  per-source packet valid; bit i belongs to source i.
- `src_data_0`, `src_data_1`, `src_data_2`  in  DATA_W each  per-source packet byte.
- `src_busy`  out  3  per-source stall; a source holds its data and valid while its bit is 1.
- `src_grant`  out  3  one-hot grant, registered.
- `rtr_busy`  in  1  router busy.
- `rtr_pkt_valid`  out  1  router packet valid.
- `rtr_data_in`  out  DATA_W  router data.
- `grant_id`  out  2  index of the granted source; valid while `src_grant` is nonzero.
- `pkt_done`  out  1  one-cycle pulse when a packet completes normally.
- `timeout`  out  1  one-cycle pulse when the DRAIN watchdog fires.

## Operation
- Registered state: `state` (IDLE, PASS, DRAIN), `gnt[1:0]`, `rr_ptr[1:0]`, `hdr_phase`, `wd_cnt[7:0]`.
- **Priority order:** `rr_ptr`, `rr_ptr`+1, `rr_ptr`+2, all mod 3. After any grant to g, `rr_ptr` becomes (g+1) mod 3, so 2 wraps to 0. Value 3 never occurs.
- **IDLE**
  - Outputs: `src_busy`=111, `rtr_pkt_valid`=0, `rtr_data_in`=0.
  - If any `src_pkt_valid` bit is set and `rtr_busy`=0: grant the highest-priority requester, update `rr_ptr`, set `hdr_phase`=1, go to PASS.
  - If `rtr_busy`=1: no grant.
- **PASS** (combinational forwarding from the granted source g)
  - `rtr_pkt_valid` = `src_pkt_valid[g]`.
  - `rtr_data_in` = `src_data_g`.
  - `src_busy[g]` = `rtr_busy`; all other bits = 1.
  - `hdr_phase` clears after the first PASS cycle.
  - If `hdr_phase`=1 and `src_pkt_valid[g]`=0 (source withdrew): abort. Go to IDLE with no `pkt_done`; the `rr_ptr` update stands.
  - If `hdr_phase`=0, `src_pkt_valid[g]`=0 and `rtr_busy`=0: the parity byte is accepted this cycle. Go to DRAIN and clear `wd_cnt`.
  - If `src_pkt_valid[g]`=0 and `rtr_busy`=1: stay in PASS and keep presenting parity.
- **DRAIN**
  - Outputs: `rtr_pkt_valid`=0, `rtr_data_in`=0, `src_busy`=111; grant stays held.
  - `wd_cnt` increments every cycle.
  - When `rtr_busy`=0 (router back in decode): go to IDLE and pulse `pkt_done`.
  - Else when `wd_cnt` = TIMEOUT−1: go to IDLE and pulse `timeout`, not `pkt_done`.
- **Grant release:** `src_grant` and `grant_id` clear on entry to IDLE. `src_grant` is one-hot (bit g) in PASS and DRAIN.
- **Unused cases:** new requests arriving during PASS or DRAIN are ignored until IDLE. A request from a non-granted source never reaches the router.
- **Reset** (any state, including mid-packet)
  - State returns to IDLE; `rr_ptr`=0, `gnt`=0, `hdr_phase`=0, `wd_cnt`=0.
  - Output values: `src_busy`=111, `src_grant`=000, `grant_id`=0, `rtr_pkt_valid`=0, `rtr_data_in`=0, `pkt_done`=0, `timeout`=0.
  - The packet is truncated; router recovery is the router's responsibility.

## Timing
- **Grant latency:** request sampled at edge N (IDLE, `rtr_busy`=0) → grant visible and header forwarded in cycle N+1.
- **Forwarding:** zero-latency combinational mux in PASS. `rtr_busy` → `src_busy[g]` is a combinational path.
- **Sources:** must hold the header and `pkt_valid` stable while `src_busy`=1.
- **DRAIN:** minimum 1 cycle.
- **Back-to-back packets:** minimum gap between two packets is 2 idle cycles on `rtr_pkt_valid` (DRAIN then IDLE).
- **Pulses:** `pkt_done` and `timeout` are registered and asserted in the first IDLE cycle.

## Test plan
- **Single packet:** source 1 sends header 8'h0D (len 3, addr 1), payload 11/22/33, parity; `rtr_busy`=0 except 2 cycles after parity → bytes reach the router unchanged, starting 1 cycle after the request; `pkt_done` pulses once; `rr_ptr`=2.
- **Round-robin order:** all three sources request continuously from reset with 1-byte payloads → grant order 0,1,2,0,1,2; no source is granted twice in a row.
- **Busy at arbitration:** `rtr_busy`=1 held for 5 cycles in IDLE with source 0 requesting → no grant during those cycles; grant in the cycle after `rtr_busy` falls.
- **Mid-payload stall:** `rtr_busy`=1 for 3 cycles mid-payload → `src_busy`=111 and the router sees the same byte for 3 cycles; no byte is lost or duplicated after release.
- **Withdrawal:** source 2 drops `pkt_valid` in its first PASS cycle → IDLE next cycle, no `pkt_done`, `rr_ptr`=0.
- **Watchdog and reset:** `rtr_busy` stuck at 1 after parity with TIMEOUT=30 → `timeout` pulse exactly 30 cycles after DRAIN entry, then IDLE. Separately, `resetn`=0 mid-PASS → all outputs at reset values next cycle.
